// File: rtl/snn_ff_ctrl_pkg.sv
// Shared definitions for the neuron event scheduler.
// Holds the scheduler state encoding, default sizing and helpers that derive
// the post-group count and the sweep counter width.
package snn_ff_ctrl_pkg;

  // Scheduler states. IDLE must stay at encoding 0 so reset lands there.
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PRE_RD    = 4'd1,
    PRE_WR    = 4'd2,
    POST_RD   = 4'd3,
    POST_WR   = 4'd4,
    TSTEP_RD  = 4'd5,
    TSTEP_WR  = 4'd6,
    TREF_POST = 4'd7,
    TREF_PRE  = 4'd8
  } sched_state_e;

  localparam int DEF_TIME_STEP          = 8;
  localparam int DEF_INPUT_NEURON       = 784;
  localparam int DEF_OUTPUT_NEURON      = 256;
  localparam int DEF_POST_NEUR_PARALLEL = 4;

  // Number of post-neuron groups (one SRAM word each).
  function automatic int sweep_groups(input int out_n, input int par);
    return out_n / par;
  endfunction

  // Counter width wide enough for the longest sweep (post groups or pre rows).
  function automatic int sweep_cnt_width(input int in_n, input int groups);
    int m;
    m = (in_n > groups) ? in_n : groups;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

  localparam int DEF_GROUPS = sweep_groups(DEF_OUTPUT_NEURON, DEF_POST_NEUR_PARALLEL);

endpackage

// File: rtl/group_sweep_counter.sv
// Sweep index counter shared by every sweep of the scheduler.
// Counts 0..limit_i-1, flags the last index, wraps to 0 when advanced on the
// last index and supports a synchronous clear. The next-state value is exported
// so the owner can register outputs that line up with the counter itself.
module group_sweep_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_next_o,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign last_o       = (count_q == (limit_i - WIDTH'(1)));
  assign count_next_o = count_d;

  // Next count: clear has priority, otherwise advance and wrap after the last index.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : (count_q + WIDTH'(1));
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/neuron_event_scheduler.sv
// Neuron event scheduler: serialises AER spike events, end-of-time-step
// sweeps and sample-reset sweeps onto the pre/post neuron SRAMs.
// All SRAM strobes and addresses are registered: the decode is evaluated on the
// next state and next counter value, so every output changes together with the
// state register and appears in the same cycle as the state it belongs to.
module neuron_event_scheduler
  import snn_ff_ctrl_pkg::*;
#(
  parameter int TIME_STEP            = DEF_TIME_STEP,
  parameter int INPUT_NEURON         = DEF_INPUT_NEURON,
  parameter int OUTPUT_NEURON        = DEF_OUTPUT_NEURON,
  parameter int POST_NEUR_PARALLEL   = DEF_POST_NEUR_PARALLEL,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               AER_IN_VALID,
  input  logic [PRE_NEUR_ADDR_WIDTH-1:0]     AER_IN_ADDR,
  output logic                               AER_IN_READY,
  input  logic                               TSTEP_REQ,
  input  logic                               TREF_REQ,
  input  logic                               SPI_GATE_ACTIVITY_sync,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]     CTRL_PRE_NEURON_ADDRESS,
  output logic [POST_NEUR_ADDR_WIDTH-1:0]    CTRL_POST_NEURON_ADDRESS,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0]    SYNARRAY_ADDR,
  output logic                               CTRL_PRE_NEUR_CS,
  output logic                               CTRL_PRE_NEUR_WE,
  output logic                               CTRL_POST_NEUR_CS,
  output logic                               CTRL_POST_NEUR_WE,
  output logic                               CTRL_PRE_CNT_EN,
  output logic                               CTRL_NEUR_EVENT,
  output logic                               CTRL_TSTEP_EVENT,
  output logic                               CTRL_TREF_EVENT,
  output logic [$clog2(TIME_STEP)-1:0]       CURRENT_TIME_STEP,
  output logic                               BUSY,
  output logic                               SAMPLE_DONE
);

  localparam int G     = sweep_groups(OUTPUT_NEURON, POST_NEUR_PARALLEL);
  localparam int CNT_W = sweep_cnt_width(INPUT_NEURON, G);
  localparam int TS_W  = $clog2(TIME_STEP);
  localparam int PRE_W = PRE_NEUR_ADDR_WIDTH;
  localparam int POST_W = POST_NEUR_ADDR_WIDTH;
  localparam int SYN_W = SYN_ARRAY_ADDR_WIDTH;

  // Control state
  sched_state_e      state_q, state_d;
  logic [PRE_W-1:0]  pre_lat_q, pre_lat_d;
  logic              tstep_pend_q, tstep_pend_d;
  logic              tref_pend_q, tref_pend_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              done_q, done_d;
  logic              serve_tstep, serve_tref;

  // Sweep counter hookup
  logic              cnt_clr, cnt_en, cnt_last;
  logic [CNT_W-1:0]  cnt_limit, cnt_next;

  // Registered outputs
  logic [PRE_W-1:0]  pre_addr_q, pre_addr_d;
  logic [POST_W-1:0] post_addr_q, post_addr_d;
  logic [SYN_W-1:0]  syn_addr_q, syn_addr_d;
  logic              pre_cs_q, pre_cs_d;
  logic              pre_we_q, pre_we_d;
  logic              post_cs_q, post_cs_d;
  logic              post_we_q, post_we_d;
  logic              pre_cnt_en_q, pre_cnt_en_d;
  logic              neur_ev_q, neur_ev_d;
  logic              tstep_ev_q, tstep_ev_d;
  logic              tref_ev_q, tref_ev_d;
  logic              busy_q, busy_d;

  // The pre-row sweep of a sample reset is the only sweep longer than G.
  assign cnt_limit = (state_q == TREF_PRE) ? CNT_W'(INPUT_NEURON) : CNT_W'(G);

  group_sweep_counter #(
    .WIDTH(CNT_W)
  ) u_sweep_cnt (
    .clk_i       (CLK),
    .srst_i      (RST),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .limit_i     (cnt_limit),
    .count_next_o(cnt_next),
    .last_o      (cnt_last)
  );

  // Events are only taken when nothing else is queued and the SPI does not own the SRAMs.
  assign AER_IN_READY = (state_q == IDLE) && !SPI_GATE_ACTIVITY_sync &&
                        !tstep_pend_q && !tref_pend_q;

  // Next-state logic: arbitration in IDLE, sweep sequencing, time-step bookkeeping.
  always_comb begin
    state_d     = state_q;
    pre_lat_d   = pre_lat_q;
    ts_d        = ts_q;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    serve_tstep = 1'b0;
    serve_tref  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!SPI_GATE_ACTIVITY_sync) begin
          if (tref_pend_q) begin
            state_d    = TREF_POST;
            serve_tref = 1'b1;
          end else if (tstep_pend_q) begin
            state_d     = TSTEP_RD;
            serve_tstep = 1'b1;
          end else if (AER_IN_VALID) begin
            state_d   = PRE_RD;
            pre_lat_d = AER_IN_ADDR;
          end
        end
      end
      PRE_RD:  state_d = PRE_WR;
      PRE_WR:  state_d = POST_RD;
      POST_RD: state_d = POST_WR;
      POST_WR: begin
        cnt_en  = 1'b1;
        state_d = cnt_last ? IDLE : POST_RD;
      end
      TSTEP_RD: state_d = TSTEP_WR;
      TSTEP_WR: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = IDLE;
          if (ts_q == TS_W'(TIME_STEP - 1)) begin
            ts_d   = '0;
            done_d = 1'b1;
          end else begin
            ts_d = ts_q + TS_W'(1);
          end
        end else begin
          state_d = TSTEP_RD;
        end
      end
      TREF_POST: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = TREF_PRE;
      end
      TREF_PRE: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = IDLE;
          ts_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky request flags: set by a pulse in any state, cleared when their sweep starts.
  // A pulse landing on the serving edge is merged into the sweep being started.
  always_comb begin
    tstep_pend_d = serve_tstep ? 1'b0 : (tstep_pend_q | TSTEP_REQ);
    tref_pend_d  = serve_tref  ? 1'b0 : (tref_pend_q  | TREF_REQ);
  end

  // Output decode for the upcoming state, so strobes register alongside the state.
  always_comb begin
    pre_addr_d   = '0;
    post_addr_d  = '0;
    syn_addr_d   = '0;
    pre_cs_d     = 1'b0;
    pre_we_d     = 1'b0;
    post_cs_d    = 1'b0;
    post_we_d    = 1'b0;
    pre_cnt_en_d = 1'b0;
    neur_ev_d    = 1'b0;
    tstep_ev_d   = 1'b0;
    tref_ev_d    = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_d)
      PRE_RD: begin
        pre_cs_d   = 1'b1;
        pre_addr_d = pre_lat_d;
      end
      PRE_WR: begin
        pre_cs_d     = 1'b1;
        pre_we_d     = 1'b1;
        pre_cnt_en_d = 1'b1;
        neur_ev_d    = 1'b1;
        pre_addr_d   = pre_lat_d;
      end
      POST_RD, POST_WR: begin
        post_cs_d   = 1'b1;
        post_we_d   = (state_d == POST_WR);
        neur_ev_d   = (state_d == POST_WR);
        pre_addr_d  = pre_lat_d;
        post_addr_d = POST_W'(cnt_next) * POST_W'(POST_NEUR_PARALLEL);
        syn_addr_d  = SYN_W'(pre_lat_d) * SYN_W'(G) + SYN_W'(cnt_next);
      end
      TSTEP_RD, TSTEP_WR: begin
        post_cs_d   = 1'b1;
        post_we_d   = (state_d == TSTEP_WR);
        tstep_ev_d  = (state_d == TSTEP_WR);
        post_addr_d = POST_W'(cnt_next) * POST_W'(POST_NEUR_PARALLEL);
      end
      TREF_POST: begin
        post_cs_d   = 1'b1;
        post_we_d   = 1'b1;
        tref_ev_d   = 1'b1;
        post_addr_d = POST_W'(cnt_next) * POST_W'(POST_NEUR_PARALLEL);
      end
      TREF_PRE: begin
        pre_cs_d   = 1'b1;
        pre_we_d   = 1'b1;
        tref_ev_d  = 1'b1;
        pre_addr_d = PRE_W'(cnt_next);
      end
      default: ;
    endcase
  end

  // State, flags and output registers; reset abandons any sweep immediately.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      pre_lat_q    <= '0;
      tstep_pend_q <= 1'b0;
      tref_pend_q  <= 1'b0;
      ts_q         <= '0;
      done_q       <= 1'b0;
      pre_addr_q   <= '0;
      post_addr_q  <= '0;
      syn_addr_q   <= '0;
      pre_cs_q     <= 1'b0;
      pre_we_q     <= 1'b0;
      post_cs_q    <= 1'b0;
      post_we_q    <= 1'b0;
      pre_cnt_en_q <= 1'b0;
      neur_ev_q    <= 1'b0;
      tstep_ev_q   <= 1'b0;
      tref_ev_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_lat_q    <= pre_lat_d;
      tstep_pend_q <= tstep_pend_d;
      tref_pend_q  <= tref_pend_d;
      ts_q         <= ts_d;
      done_q       <= done_d;
      pre_addr_q   <= pre_addr_d;
      post_addr_q  <= post_addr_d;
      syn_addr_q   <= syn_addr_d;
      pre_cs_q     <= pre_cs_d;
      pre_we_q     <= pre_we_d;
      post_cs_q    <= post_cs_d;
      post_we_q    <= post_we_d;
      pre_cnt_en_q <= pre_cnt_en_d;
      neur_ev_q    <= neur_ev_d;
      tstep_ev_q   <= tstep_ev_d;
      tref_ev_q    <= tref_ev_d;
      busy_q       <= busy_d;
    end
  end

  assign CTRL_PRE_NEURON_ADDRESS  = pre_addr_q;
  assign CTRL_POST_NEURON_ADDRESS = post_addr_q;
  assign SYNARRAY_ADDR            = syn_addr_q;
  assign CTRL_PRE_NEUR_CS         = pre_cs_q;
  assign CTRL_PRE_NEUR_WE         = pre_we_q;
  assign CTRL_POST_NEUR_CS        = post_cs_q;
  assign CTRL_POST_NEUR_WE        = post_we_q;
  assign CTRL_PRE_CNT_EN          = pre_cnt_en_q;
  assign CTRL_NEUR_EVENT          = neur_ev_q;
  assign CTRL_TSTEP_EVENT         = tstep_ev_q;
  assign CTRL_TREF_EVENT          = tref_ev_q;
  assign CURRENT_TIME_STEP        = ts_q;
  assign BUSY                     = busy_q;
  assign SAMPLE_DONE              = done_q;

endmodule

// File: doc/neuron_event_scheduler.md
NEURON_EVENT_SCHEDULER -- requirements
Module: neuron_event_scheduler

Interface
REQ-001 SHALL have parameters: TIME_STEP 8, number of time steps per sample; INPUT_NEURON 784, number of pre-neurons; OUTPUT_NEURON 256, number of post-neurons; POST_NEUR_PARALLEL 4, post-neurons per SRAM word; PRE_NEUR_ADDR_WIDTH 10; POST_NEUR_ADDR_WIDTH 10; SYN_ARRAY_ADDR_WIDTH 16.
REQ-002 SHALL have one clock and a synchronous active-high reset: CLK in 1, rising-edge clock; RST in 1, synchronous active-high reset.
REQ-003 SHALL have the AER input handshake: AER_IN_VALID in 1, event valid; AER_IN_ADDR in PRE_NEUR_ADDR_WIDTH, pre-neuron index; AER_IN_READY out 1, event accepted when VALID and READY are both high.
REQ-004 SHALL have the request and gating inputs: TSTEP_REQ in 1, end-of-time-step pulse; TREF_REQ in 1, sample-reset pulse; SPI_GATE_ACTIVITY_sync in 1, SPI owns the SRAMs.
REQ-005 SHALL have the address outputs: CTRL_PRE_NEURON_ADDRESS out PRE_NEUR_ADDR_WIDTH; CTRL_POST_NEURON_ADDRESS out POST_NEUR_ADDR_WIDTH, always group*POST_NEUR_PARALLEL; SYNARRAY_ADDR out SYN_ARRAY_ADDR_WIDTH.
REQ-006 SHALL have the strobe outputs, each 1 bit: CTRL_PRE_NEUR_CS, CTRL_PRE_NEUR_WE, CTRL_POST_NEUR_CS, CTRL_POST_NEUR_WE, CTRL_PRE_CNT_EN, CTRL_NEUR_EVENT, CTRL_TSTEP_EVENT, CTRL_TREF_EVENT.
REQ-007 SHALL have the status outputs: CURRENT_TIME_STEP out clog2(TIME_STEP); BUSY out 1; SAMPLE_DONE out 1, one-cycle pulse.

Function
REQ-008 SHALL implement FSM states IDLE, PRE_RD, PRE_WR, POST_RD, POST_WR, TSTEP_RD, TSTEP_WR, TREF_POST, TREF_PRE.
REQ-009 In IDLE, AER_IN_READY SHALL be 1 only when SPI_GATE_ACTIVITY_sync=0 and no TSTEP or TREF request is pending.
REQ-010 Arbitration in IDLE SHALL be TREF pending > TSTEP pending > AER event; SPI gate high blocks all three.
REQ-011 TSTEP_REQ and TREF_REQ pulses SHALL set sticky pending flags in any state; a duplicate pulse while the flag is set SHALL merge; the flag SHALL clear on entry to the serving sweep.
REQ-012 AER event sequence: PRE_RD drives PRE CS=1, WE=0, address=AER_IN_ADDR (latched); PRE_WR drives PRE CS=1, WE=1, CTRL_PRE_CNT_EN=1, CTRL_NEUR_EVENT=1.
REQ-013 Post sweep: for g=0..G-1, where G=OUTPUT_NEURON/POST_NEUR_PARALLEL: POST_RD drives POST CS=1, WE=0, SYNARRAY_ADDR=pre*G+g; POST_WR drives POST CS=1, WE=1, CTRL_NEUR_EVENT=1 with the same addresses.
REQ-014 Latency SHALL be exactly 2+2G cycles from AER acceptance to return to IDLE (130 cycles for G=64).
REQ-015 TSTEP sweep SHALL mirror the post sweep using TSTEP_RD/TSTEP_WR with CTRL_TSTEP_EVENT=1 in the write cycles and no NEUR_EVENT.
REQ-016 On completion of the TSTEP sweep, CURRENT_TIME_STEP SHALL increment; when it is at TIME_STEP-1 it SHALL wrap to 0 and SAMPLE_DONE SHALL pulse.
REQ-017 TREF sweep SHALL write every post group (TREF_POST), then every pre address 0..INPUT_NEURON-1 (TREF_PRE), each with CS=WE=1 and CTRL_TREF_EVENT=1, then clear CURRENT_TIME_STEP to 0.
REQ-018 SPI_GATE_ACTIVITY_sync rising mid-sweep SHALL NOT abort the sweep; all CS SHALL be 0 from the first IDLE cycle while the gate is high.
REQ-019 All strobes SHALL be registered outputs; only one SRAM write SHALL be asserted per cycle.
REQ-020 BUSY SHALL be 1 in every state other than IDLE.

Reset
REQ-021 With RST=1 at a clock edge, the block SHALL enter IDLE with all outputs, counters, latched addresses and pending flags set to 0; RST mid-sweep SHALL abandon the sweep with no further CS on the next cycle.

Structure
REQ-022 The FSM state encoding, G, and the derived widths SHALL live in a shared package snn_ff_ctrl_pkg.
REQ-023 A single sub-module, group_sweep_counter (count 0..N-1, last-flag, synchronous clear), SHALL be used by all sweeps.

Verification
REQ-024 Reset, then one AER event addr=5 -> PRE read/write at address 5; POST addresses 0,4,...,252; SYNARRAY_ADDR 320..383; READY returns high at cycle 131.
REQ-025 Eight TSTEP_REQ pulses, each separated by more than 130 cycles -> CURRENT_TIME_STEP steps 1..7 then 0; exactly one SAMPLE_DONE pulse, on the eighth.
REQ-026 TSTEP_REQ and TREF_REQ in the same cycle while IDLE -> TREF sweep of 64+784 writes runs first, then the TSTEP sweep; final CURRENT_TIME_STEP=1.
REQ-027 AER valid held high with SPI gate high for 50 cycles -> READY=0 and no CS asserted; gate low -> event accepted next cycle.
REQ-028 RST asserted at the 40th cycle of a post sweep -> the next cycle has all outputs 0 and BUSY=0.
REQ-029 TSTEP_REQ pulsed three times during one AER sweep -> exactly one TSTEP sweep follows and CURRENT_TIME_STEP increments by 1.
